// File: rtl/pipe_stage_buffer_pkg.sv
// Shared pipeline-register definitions: buffer state encoding and default field widths.
// Reused by the IF/ID, ID/EX, EX/MEM and MEM/WB stage buffers.
package pipe_stage_buffer_pkg;

  localparam int DEFAULT_DATA_W  = 20;
  localparam int DEFAULT_INSTR_W = 20;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  function automatic logic [1:0] occupancy_of(input buf_state_e st);
    case (st)
      ST_HALF: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Width-parameterised enable register with synchronous active-high clear.
// One-cycle latency; holds its value whenever load is low.
module pipe_payload_reg #(
  parameter int W = 41
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Two-entry skid buffer between EX and MEM: main register drives outputs, skid absorbs one extra entry.
// One-cycle latency; in_ready depends only on registered state, so out_ready never combinationally reaches upstream.
module pipe_stage_buffer
  import pipe_stage_buffer_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int INSTR_W = DEFAULT_INSTR_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instruction,
  input  logic [DATA_W-1:0]  in_alu_result,
  input  logic               in_alu_zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instruction,
  output logic [DATA_W-1:0]  out_alu_result,
  output logic               out_alu_zero,
  output logic [1:0]         occupancy
);

  localparam int PAY_W = INSTR_W + DATA_W + 1;

  buf_state_e       state_q;
  buf_state_e       state_d;
  logic             accept;
  logic             consume;
  logic             main_load;
  logic             skid_load;
  logic             main_from_skid;
  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] main_d;
  logic [PAY_W-1:0] main_q;
  logic [PAY_W-1:0] skid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = occupancy_of(state_q);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      // Squash: a same-cycle consume still completes downstream, but nothing new is captured.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = ST_HALF;
          end
        end
        ST_HALF: begin
          if (accept && !consume) begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end else if (accept && consume) begin
            main_load = 1'b1;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_HALF;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign in_pay = {in_instruction, in_alu_result, in_alu_zero};
  assign main_d = main_from_skid ? skid_q : in_pay;

  pipe_payload_reg #(.W(PAY_W)) u_main (
    .clock (clock),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_payload_reg #(.W(PAY_W)) u_skid (
    .clock (clock),
    .reset (reset),
    .load  (skid_load),
    .d     (in_pay),
    .q     (skid_q)
  );

  assign {out_instruction, out_alu_result, out_alu_zero} = main_q;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Scoreboard bench for pipe_stage_buffer: driver pushes expected entries, negedge monitor pops and compares.
module tb_pipe_stage_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] in_instruction = '0;
  logic [19:0] in_alu_result = '0;
  logic        in_alu_zero = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [19:0] out_instruction;
  logic [19:0] out_alu_result;
  logic        out_alu_zero;
  logic [1:0]  occupancy;

  logic        in_valid32 = 1'b0;
  logic        in_ready32;
  logic [31:0] in_instruction32 = '0;
  logic [31:0] in_alu_result32 = '0;
  logic        in_alu_zero32 = 1'b0;
  logic        out_valid32;
  logic        out_ready32 = 1'b0;
  logic [31:0] out_instruction32;
  logic [31:0] out_alu_result32;
  logic        out_alu_zero32;
  logic [1:0]  occupancy32;
  logic        flush32 = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int m_occ   = 0;
  logic [40:0] exp_q[$];

  always #5 clock = ~clock;

  pipe_stage_buffer dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_alu_result(in_alu_result), .in_alu_zero(in_alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_alu_result(out_alu_result), .out_alu_zero(out_alu_zero),
    .occupancy(occupancy)
  );

  pipe_stage_buffer #(.DATA_W(32), .INSTR_W(32)) dut32 (
    .clock(clock), .reset(reset), .flush(flush32),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .in_instruction(in_instruction32), .in_alu_result(in_alu_result32), .in_alu_zero(in_alu_zero32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .out_instruction(out_instruction32), .out_alu_result(out_alu_result32), .out_alu_zero(out_alu_zero32),
    .occupancy(occupancy32)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state m_occ is the buffer occupancy after the most recent rising edge.
  always @(negedge clock) begin
    logic cons;
    logic acc;
    chk("out_valid", 64'(out_valid), 64'(m_occ != 0));
    chk("in_ready", 64'(in_ready), 64'(m_occ != 2));
    chk("occupancy", 64'(occupancy), 64'(m_occ));
    cons = (m_occ != 0) && out_ready;
    if (cons) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'(1), 64'(0));
      end else begin
        chk("out_payload", 64'({out_instruction, out_alu_result, out_alu_zero}), 64'(exp_q.pop_front()));
      end
    end
    if (reset || flush) begin
      m_occ = 0;
      exp_q.delete();
    end else begin
      acc   = in_valid && (m_occ != 2);
      m_occ = m_occ + int'(acc) - int'(cons);
    end
  end

  task automatic drive(input bit v, input logic [19:0] ins, input logic [19:0] res,
                       input bit z, input bit ordy, input bit fl = 1'b0);
    in_valid       = v;
    in_instruction = ins;
    in_alu_result  = res;
    in_alu_zero    = z;
    out_ready      = ordy;
    flush          = fl;
    if (v && m_occ != 2 && !fl && !reset) exp_q.push_back({ins, res, z});
    @(posedge clock);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_occ"}, 64'(occupancy), 64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk_idle("reset");
    chk("reset_instr", 64'(out_instruction), 64'(0));
    chk("reset_result", 64'(out_alu_result), 64'(0));
    chk("reset_zero", 64'(out_alu_zero), 64'(0));

    // Single entry, one-cycle latency
    drive(1, 20'h12345, 20'h000AB, 1, 1);
    chk("lat_out_valid", 64'(out_valid), 64'(1));
    chk("lat_instr", 64'(out_instruction), 64'h12345);
    chk("lat_result", 64'(out_alu_result), 64'h000AB);
    chk("lat_zero", 64'(out_alu_zero), 64'(1));
    chk("lat_occ", 64'(occupancy), 64'(1));
    drive(0, 0, 0, 0, 1);

    // Backpressure fills skid, then drain in order
    drive(1, 20'h00001, 20'h00001, 0, 0);
    drive(1, 20'h00002, 20'h00002, 0, 0);
    chk("full_occ", 64'(occupancy), 64'(2));
    chk("full_in_ready", 64'(in_ready), 64'(0));
    drive(1, 20'h0DEAD, 20'h0DEAD, 0, 0);
    chk("full_head_held", 64'(out_alu_result), 64'h00001);
    drive(0, 0, 0, 0, 1);
    chk("drain_second", 64'(out_alu_result), 64'h00002);
    drive(0, 0, 0, 0, 1);
    chk_idle("drained");

    // Streaming at full rate
    for (int i = 0; i < 16; i++) drive(1, 20'(i + 'h100), 20'(i), i[0], 1);
    chk("stream_occ", 64'(occupancy), 64'(1));
    drive(0, 0, 0, 0, 1);

    // Flush while FULL with a new offer
    drive(1, 20'h00001, 20'h00001, 0, 0);
    drive(1, 20'h00002, 20'h00002, 0, 0);
    drive(1, 20'h00003, 20'h00003, 1, 0, 1);
    chk_idle("flush");
    drive(0, 0, 0, 0, 1);

    // Flush with a same-cycle consume
    drive(1, 20'h00044, 20'h00044, 0, 0);
    drive(1, 20'h00055, 20'h00055, 0, 1, 1);
    chk_idle("flush_consume");

    // Reset while FULL
    drive(1, 20'h00006, 20'h00006, 0, 0);
    drive(1, 20'h00007, 20'h00007, 1, 0);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    reset = 1'b0;
    chk_idle("midreset");
    chk("midreset_instr", 64'(out_instruction), 64'(0));
    chk("midreset_result", 64'(out_alu_result), 64'(0));
    chk("midreset_zero", 64'(out_alu_zero), 64'(0));
    drive(1, 20'h00008, 20'h00008, 1, 1);
    chk("post_reset_accept", 64'(out_alu_result), 64'h00008);
    drive(0, 0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 1000; i++)
      drive(1'($urandom_range(1)), 20'($urandom), 20'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1);
    chk("random_leftover", 64'(exp_q.size()), 64'(0));
    chk_idle("random_end");

    // Wide instance
    in_valid32       = 1'b1;
    in_instruction32 = 32'hDEADBEEF;
    in_alu_result32  = 32'hDEADBEEF;
    in_alu_zero32    = 1'b1;
    out_ready32      = 1'b1;
    @(posedge clock);
    #1;
    in_valid32 = 1'b0;
    chk("w32_out_valid", 64'(out_valid32), 64'(1));
    chk("w32_instr", 64'(out_instruction32), 64'hDEADBEEF);
    chk("w32_result", 64'(out_alu_result32), 64'hDEADBEEF);
    chk("w32_zero", 64'(out_alu_zero32), 64'(1));
    chk("w32_occ", 64'(occupancy32), 64'(1));
    chk("w32_in_ready", 64'(in_ready32), 64'(1));
    @(posedge clock);
    #1;
    chk("w32_drained", 64'(out_valid32), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buffer.md
PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 20, width of ALU result field.
REQ-002 SHALL have parameter INSTR_W, default 20, width of instruction field.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  discard all held entries (branch/jump squash).
REQ-006 SHALL have port in_valid  input  1  upstream (EX) entry present.
REQ-007 SHALL have port in_ready  output  1  buffer can accept an entry this cycle.
REQ-008 SHALL have ports in_instruction  input  INSTR_W; in_alu_result  input  DATA_W; in_alu_zero  input  1  entry payload.
REQ-009 SHALL have port out_valid  output  1  downstream (MEM) entry present.
REQ-010 SHALL have port out_ready  input  1  downstream consumes entry this cycle.
REQ-011 SHALL have ports out_instruction  output  INSTR_W; out_alu_result  output  DATA_W; out_alu_zero  output  1  head payload.
REQ-012 SHALL have port occupancy  output  2  number of held entries, 0..2.

Function
REQ-013 SHALL hold up to two entries: main (head, drives outputs) and skid (backup).
REQ-014 SHALL implement states EMPTY (0 entries), HALF (main only), FULL (main+skid); occupancy = 0/1/2 respectively.
REQ-015 SHALL drive in_ready = 1 in EMPTY and HALF, 0 in FULL; in_ready SHALL be a registered function of state, never of out_ready.
REQ-016 SHALL define accept = in_valid & in_ready, consume = out_valid & out_ready.
REQ-017 SHALL drive out_valid = 1 exactly in HALF and FULL; out_* payload SHALL be main-register contents, stable while out_valid & !out_ready.
REQ-018 EMPTY: accept -> load main, go HALF; else stay.
REQ-019 HALF: accept & !consume -> load skid, go FULL; accept & consume -> load main, stay HALF; !accept & consume -> go EMPTY; else stay.
REQ-020 FULL: consume -> move skid to main, go HALF; else stay (no accept possible).
REQ-021 Latency: entry accepted in cycle N SHALL appear on out_* with out_valid in cycle N+1 when buffer was EMPTY or consumed in cycle N.
REQ-022 Order SHALL be preserved; no entry SHALL be duplicated or dropped except by flush/reset.
REQ-023 flush SHALL override all other inputs: next state EMPTY, any entry offered the same cycle discarded, occupancy 0 next cycle.
REQ-024 A consume in the flush cycle SHALL still be a valid transfer downstream (downstream saw out_valid); it is not counted twice.
REQ-025 Payload fields SHALL pass through unmodified, width-exact; no arithmetic on data.
REQ-026 Payload registers SHALL load only on accept (main or skid) or skid->main move; otherwise hold.

Reset
REQ-027 reset SHALL take priority over flush and all handshakes.
REQ-028 On reset: state EMPTY, out_valid 0, in_ready 1, occupancy 0, out_instruction 0, out_alu_result 0, out_alu_zero 0, skid payload 0.
REQ-029 Reset asserted mid-operation SHALL discard held entries in the same edge; first accept possible the cycle after reset deasserts.

Structure
REQ-030 State encoding (EMPTY/HALF/FULL) and default widths SHALL live in the shared pipeline package for reuse by IF/ID, ID/EX, MEM/WB stages.
REQ-031 SHALL be a single module; an optional sub-module pipe_payload_reg (width-parameterised enable register with sync reset) is natural for main and skid storage.

Verification
REQ-032 Reset then in_valid=1, instr=0x12345, result=0x000AB, zero=1, out_ready=1 -> next cycle out_valid=1, out_* = 0x12345/0x000AB/1, occupancy=1.
REQ-033 out_ready=0, push A=0x00001, B=0x00002 -> occupancy=2, in_ready=0, out=A held; raise out_ready -> A then B on consecutive cycles, then out_valid=0.
REQ-034 Continuous in_valid=1 and out_ready=1 with incrementing results 0..15 -> 16 entries out in order, one per cycle, occupancy stays 1.
REQ-035 FULL, flush=1 with in_valid=1 (C=0x00003) -> next cycle occupancy=0, out_valid=0, in_ready=1; C never appears.
REQ-036 FULL, reset=1 and flush=0 -> next cycle all outputs per REQ-028; with DATA_W=32, INSTR_W=32 repeat REQ-032 using 0xDEADBEEF -> passes unchanged.
REQ-037 Random in_valid/out_ready (50%) for 1000 cycles vs scoreboard -> no loss, no duplication, in_ready never 1 while occupancy=2.
